// File: rtl/instr_fetch_unit_pkg.sv
// Shared RISC-V core constants for the instruction fetch path.
package instr_fetch_unit_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_FETCH = 2'b01,
      ST_FAULT = 2'b10
   } fetch_state_t;

   localparam logic [31:0] PC_INCR          = 32'd4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   // One buffered instruction: where it came from and the word itself.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   // Instruction addresses must be word aligned.
   function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
      return (addr_lsb == 2'b00);
   endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-side bus: instruction memory port, redirect request and decode handshake.
interface instr_fetch_unit_if;
   logic        fetch_en;
   logic [31:0] imem_addr;
   logic [31:0] imem_rd;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        fetch_fault;

   // Fetch unit side.
   modport master (
      input  fetch_en, imem_rd, redirect_valid, redirect_target, if_ready,
      output imem_addr, if_valid, if_instr, if_pc, fetch_fault
   );

   // Core / memory / decode side.
   modport slave (
      output fetch_en, imem_rd, redirect_valid, redirect_target, if_ready,
      input  imem_addr, if_valid, if_instr, if_pc, fetch_fault
   );
endinterface

// File: rtl/instr_fetch_unit_fetch_buffer.sv
// Small synchronous FIFO holding fetched {pc, instr} pairs, with flush.
module fetch_buffer #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_flush,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_wdata,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_empty,
   output logic             o_full
);
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == CW'(DEPTH));
   assign o_rdata   = r_mem[r_rd_ptr];
   // A full buffer still accepts a write when the head leaves in the same cycle.
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);

   // Pointer and occupancy tracking; flush empties the buffer outright.
   always_ff @(posedge clk) begin
      if (!rst_n || i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage write; contents need no reset since occupancy gates visibility.
   always_ff @(posedge clk) begin
      if (rst_n && !i_flush && w_do_push) r_mem[r_wr_ptr] <= i_wdata;
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC sequencing, redirect handling and a small fetch buffer.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | not fetching; PC and buffer held, redirects still accepted
//   ST_FETCH | one fetch per cycle while the buffer has room
//   ST_FAULT | misaligned redirect seen; buffer empty, left only by reset
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int unsigned DEPTH    = 2
) (
   input logic                 clk,
   input logic                 rst_n,
   instr_fetch_unit_if.master  bus
);
   fetch_state_t r_state;
   logic [31:0]  r_pc;
   logic         r_fault;

   logic         w_redirect;
   logic         w_redirect_ok;
   logic         w_push;
   logic         w_pop;
   logic         w_empty;
   logic         w_full;
   logic         w_valid;
   fetch_entry_t w_wentry;
   fetch_entry_t w_head;

   // FAULT ignores redirects entirely; anywhere else a redirect flushes and
   // blocks both push and pop for that cycle.
   assign w_redirect    = bus.redirect_valid && (r_state != ST_FAULT);
   assign w_redirect_ok = is_word_aligned(bus.redirect_target[1:0]);
   assign w_valid       = !w_empty;
   assign w_pop         = w_valid && bus.if_ready && !w_redirect;
   assign w_push        = (r_state == ST_FETCH) && !bus.redirect_valid
                          && (!w_full || w_pop);

   assign w_wentry.pc    = r_pc;
   assign w_wentry.instr = bus.imem_rd;

   fetch_buffer #(
      .DEPTH (DEPTH),
      .WIDTH (64)
   ) u_fetch_buffer (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_flush (w_redirect),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_wdata (w_wentry),
      .o_rdata (w_head),
      .o_empty (w_empty),
      .o_full  (w_full)
   );

   // Head of buffer goes straight to decode; zeroed when nothing is buffered.
   assign bus.imem_addr   = r_pc;
   assign bus.if_valid    = w_valid;
   assign bus.if_instr    = w_valid ? w_head.instr : 32'h0;
   assign bus.if_pc       = w_valid ? w_head.pc    : 32'h0;
   assign bus.fetch_fault = r_fault;

   // Fetch controller: state, PC and sticky fault flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_pc    <= RESET_PC;
         r_fault <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_redirect) begin
                  if (w_redirect_ok) begin
                     r_pc <= bus.redirect_target;
                  end else begin
                     r_fault <= 1'b1;
                     r_state <= ST_FAULT;
                  end
               end else if (bus.fetch_en) begin
                  r_state <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               if (w_redirect) begin
                  if (w_redirect_ok) begin
                     r_pc <= bus.redirect_target;
                  end else begin
                     r_fault <= 1'b1;
                     r_state <= ST_FAULT;
                  end
               end else begin
                  if (w_push) r_pc <= r_pc + PC_INCR;
                  if (!bus.fetch_en) r_state <= ST_IDLE;
               end
            end
            ST_FAULT: begin
               r_state <= ST_FAULT;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
   logic clk;
   logic rst_n1;
   logic rst_n2;
   int   total;
   int   bad;

   instr_fetch_unit_if bus1();
   instr_fetch_unit_if bus2();

   instr_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) u_dut1 (
      .clk   (clk),
      .rst_n (rst_n1),
      .bus   (bus1.master)
   );

   instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) u_dut2 (
      .clk   (clk),
      .rst_n (rst_n2),
      .bus   (bus2.master)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hA5C3_0F13;
   endfunction

   assign bus1.imem_rd = mem_word(bus1.imem_addr);
   assign bus2.imem_rd = mem_word(bus2.imem_addr);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n1 = 1'b0;
      rst_n2 = 1'b0;
      bus1.fetch_en = 1'b0; bus1.redirect_valid = 1'b0;
      bus1.redirect_target = 32'h0; bus1.if_ready = 1'b0;
      bus2.fetch_en = 1'b0; bus2.redirect_valid = 1'b0;
      bus2.redirect_target = 32'h0; bus2.if_ready = 1'b0;
      tick(); tick();
      total++; if (bus1.if_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", bus1.if_valid); end
      total++; if (bus1.imem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h want=00000000", bus1.imem_addr); end
      total++; if (bus1.if_instr !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h want=00000000", bus1.if_instr); end
      total++; if (bus1.if_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h want=00000000", bus1.if_pc); end
      total++; if (bus1.fetch_fault !== 1'b0) begin bad++; $display("FAIL reset_fault got=%0b want=0", bus1.fetch_fault); end
      total++; if (bus2.imem_addr !== 32'hFFFF_FFF8) begin bad++; $display("FAIL reset_addr2 got=%h want=fffffff8", bus2.imem_addr); end
      total++; if (bus2.if_valid !== 1'b0) begin bad++; $display("FAIL reset_valid2 got=%0b want=0", bus2.if_valid); end
   endtask

   task automatic test_stream();
      logic [31:0] exp_pc;
      rst_n1 = 1'b1;
      bus1.fetch_en = 1'b1;
      bus1.if_ready = 1'b1;
      tick();
      total++; if (bus1.if_valid !== 1'b0) begin bad++; $display("FAIL stream_first_valid got=%0b want=0", bus1.if_valid); end
      total++; if (bus1.imem_addr !== 32'h0) begin bad++; $display("FAIL stream_first_addr got=%h want=00000000", bus1.imem_addr); end
      for (int i = 0; i < 4; i++) begin
         tick();
         exp_pc = 32'(4 * i);
         total++; if (bus1.if_valid !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d] got=%0b want=1", i, bus1.if_valid); end
         total++; if (bus1.if_pc !== exp_pc) begin bad++; $display("FAIL stream_pc[%0d] got=%h want=%h", i, bus1.if_pc, exp_pc); end
         total++; if (bus1.if_instr !== mem_word(exp_pc)) begin bad++; $display("FAIL stream_instr[%0d] got=%h want=%h", i, bus1.if_instr, mem_word(exp_pc)); end
         total++; if (bus1.imem_addr !== exp_pc + 32'd4) begin bad++; $display("FAIL stream_addr[%0d] got=%h want=%h", i, bus1.imem_addr, exp_pc + 32'd4); end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] exp_pc;
      bus1.if_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         total++; if (bus1.if_valid !== 1'b1) begin bad++; $display("FAIL hold_valid[%0d] got=%0b want=1", i, bus1.if_valid); end
         total++; if (bus1.if_pc !== 32'd12) begin bad++; $display("FAIL hold_pc[%0d] got=%h want=0000000c", i, bus1.if_pc); end
         total++; if (bus1.if_instr !== mem_word(32'd12)) begin bad++; $display("FAIL hold_instr[%0d] got=%h want=%h", i, bus1.if_instr, mem_word(32'd12)); end
      end
      total++; if (bus1.imem_addr !== 32'd20) begin bad++; $display("FAIL hold_addr got=%h want=00000014", bus1.imem_addr); end
      bus1.if_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         exp_pc = 32'(16 + 4 * i);
         total++; if (bus1.if_valid !== 1'b1) begin bad++; $display("FAIL drain_valid[%0d] got=%0b want=1", i, bus1.if_valid); end
         total++; if (bus1.if_pc !== exp_pc) begin bad++; $display("FAIL drain_pc[%0d] got=%h want=%h", i, bus1.if_pc, exp_pc); end
         total++; if (bus1.if_instr !== mem_word(exp_pc)) begin bad++; $display("FAIL drain_instr[%0d] got=%h want=%h", i, bus1.if_instr, mem_word(exp_pc)); end
      end
   endtask

   task automatic test_redirect();
      bus1.if_ready = 1'b0;
      tick();
      bus1.redirect_valid = 1'b1;
      bus1.redirect_target = 32'h20;
      bus1.if_ready = 1'b1;
      tick();
      total++; if (bus1.if_valid !== 1'b0) begin bad++; $display("FAIL redir_valid got=%0b want=0", bus1.if_valid); end
      total++; if (bus1.imem_addr !== 32'h20) begin bad++; $display("FAIL redir_addr got=%h want=00000020", bus1.imem_addr); end
      bus1.redirect_valid = 1'b0;
      tick();
      total++; if (bus1.if_valid !== 1'b1) begin bad++; $display("FAIL redir_tgt_valid got=%0b want=1", bus1.if_valid); end
      total++; if (bus1.if_pc !== 32'h20) begin bad++; $display("FAIL redir_tgt_pc got=%h want=00000020", bus1.if_pc); end
      total++; if (bus1.if_instr !== mem_word(32'h20)) begin bad++; $display("FAIL redir_tgt_instr got=%h want=%h", bus1.if_instr, mem_word(32'h20)); end
      // Pause into IDLE, then redirect from IDLE.
      bus1.fetch_en = 1'b0;
      bus1.if_ready = 1'b0;
      tick();
      total++; if (bus1.if_pc !== 32'h20) begin bad++; $display("FAIL idle_keep_pc got=%h want=00000020", bus1.if_pc); end
      bus1.redirect_valid = 1'b1;
      bus1.redirect_target = 32'h100;
      tick();
      total++; if (bus1.if_valid !== 1'b0) begin bad++; $display("FAIL idle_redir_valid got=%0b want=0", bus1.if_valid); end
      total++; if (bus1.imem_addr !== 32'h100) begin bad++; $display("FAIL idle_redir_addr got=%h want=00000100", bus1.imem_addr); end
      bus1.redirect_valid = 1'b0;
      tick();
      total++; if (bus1.imem_addr !== 32'h100) begin bad++; $display("FAIL idle_stay_addr got=%h want=00000100", bus1.imem_addr); end
      total++; if (bus1.if_valid !== 1'b0) begin bad++; $display("FAIL idle_stay_valid got=%0b want=0", bus1.if_valid); end
      bus1.fetch_en = 1'b1;
      bus1.if_ready = 1'b1;
      tick();
      total++; if (bus1.if_valid !== 1'b0) begin bad++; $display("FAIL resume_valid0 got=%0b want=0", bus1.if_valid); end
      tick();
      total++; if (bus1.if_pc !== 32'h100) begin bad++; $display("FAIL resume_pc got=%h want=00000100", bus1.if_pc); end
   endtask

   task automatic test_fault();
      bus1.redirect_valid = 1'b1;
      bus1.redirect_target = 32'h22;
      tick();
      total++; if (bus1.fetch_fault !== 1'b1) begin bad++; $display("FAIL fault_set got=%0b want=1", bus1.fetch_fault); end
      total++; if (bus1.if_valid !== 1'b0) begin bad++; $display("FAIL fault_valid got=%0b want=0", bus1.if_valid); end
      bus1.redirect_target = 32'h40;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (bus1.fetch_fault !== 1'b1) begin bad++; $display("FAIL fault_sticky[%0d] got=%0b want=1", i, bus1.fetch_fault); end
         total++; if (bus1.if_valid !== 1'b0) begin bad++; $display("FAIL fault_novalid[%0d] got=%0b want=0", i, bus1.if_valid); end
      end
      bus1.redirect_valid = 1'b0;
      rst_n1 = 1'b0;
      tick();
      total++; if (bus1.fetch_fault !== 1'b0) begin bad++; $display("FAIL fault_clear got=%0b want=0", bus1.fetch_fault); end
      total++; if (bus1.imem_addr !== 32'h0) begin bad++; $display("FAIL fault_rst_addr got=%h want=00000000", bus1.imem_addr); end
   endtask

   task automatic test_reset_mid();
      rst_n1 = 1'b1;
      bus1.fetch_en = 1'b1;
      bus1.if_ready = 1'b0;
      tick(); tick(); tick();
      total++; if (bus1.if_pc !== 32'h0 || bus1.if_valid !== 1'b1) begin bad++; $display("FAIL mid_pre got=%h/%0b want=00000000/1", bus1.if_pc, bus1.if_valid); end
      total++; if (bus1.imem_addr !== 32'h8) begin bad++; $display("FAIL mid_pre_addr got=%h want=00000008", bus1.imem_addr); end
      rst_n1 = 1'b0;
      bus1.if_ready = 1'b1;
      bus1.redirect_valid = 1'b1;
      bus1.redirect_target = 32'h80;
      tick();
      total++; if (bus1.if_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%0b want=0", bus1.if_valid); end
      total++; if (bus1.imem_addr !== 32'h0) begin bad++; $display("FAIL mid_addr got=%h want=00000000", bus1.imem_addr); end
      total++; if (bus1.if_pc !== 32'h0 || bus1.if_instr !== 32'h0) begin bad++; $display("FAIL mid_head got=%h/%h want=0/0", bus1.if_pc, bus1.if_instr); end
      rst_n1 = 1'b1;
      bus1.redirect_valid = 1'b0;
      tick();
      total++; if (bus1.if_valid !== 1'b0) begin bad++; $display("FAIL mid_idle_valid got=%0b want=0", bus1.if_valid); end
      tick();
      total++; if (bus1.if_valid !== 1'b1 || bus1.if_pc !== 32'h0) begin bad++; $display("FAIL mid_resume0 got=%0b/%h want=1/00000000", bus1.if_valid, bus1.if_pc); end
      tick();
      total++; if (bus1.if_pc !== 32'h4) begin bad++; $display("FAIL mid_resume1 got=%h want=00000004", bus1.if_pc); end
   endtask

   task automatic test_wrap();
      logic [31:0] exp_pc;
      rst_n2 = 1'b1;
      bus2.fetch_en = 1'b1;
      bus2.if_ready = 1'b1;
      tick();
      total++; if (bus2.if_valid !== 1'b0) begin bad++; $display("FAIL wrap_first_valid got=%0b want=0", bus2.if_valid); end
      for (int i = 0; i < 4; i++) begin
         tick();
         exp_pc = 32'hFFFF_FFF8 + 32'(4 * i);
         total++; if (bus2.if_pc !== exp_pc) begin bad++; $display("FAIL wrap_pc[%0d] got=%h want=%h", i, bus2.if_pc, exp_pc); end
         total++; if (bus2.if_instr !== mem_word(exp_pc)) begin bad++; $display("FAIL wrap_instr[%0d] got=%h want=%h", i, bus2.if_instr, mem_word(exp_pc)); end
      end
      total++; if (bus2.fetch_fault !== 1'b0) begin bad++; $display("FAIL wrap_fault got=%0b want=0", bus2.fetch_fault); end
      bus2.if_ready = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      total++; if (bus2.if_pc !== 32'h4) begin bad++; $display("FAIL deep_hold_pc got=%h want=00000004", bus2.if_pc); end
      total++; if (bus2.imem_addr !== 32'd20) begin bad++; $display("FAIL deep_sat_addr got=%h want=00000014", bus2.imem_addr); end
      bus2.if_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         exp_pc = 32'(8 + 4 * i);
         total++; if (bus2.if_valid !== 1'b1 || bus2.if_pc !== exp_pc) begin bad++; $display("FAIL deep_drain[%0d] got=%0b/%h want=1/%h", i, bus2.if_valid, bus2.if_pc, exp_pc); end
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_fault();
      test_reset_mid();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
